// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared types for the page-table-walker memory arbiter: fault codes,
// arbiter state encoding, latched request payload and debug view.
package ptw_mem_arbiter_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FE_NONE         = 2'd0,
    FE_PAGE_FAULT   = 2'd1,
    FE_ACCESS_FAULT = 2'd2
  } FaultTy;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arbstate;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
  } req_payload_t;

  typedef struct packed {
    arbstate state;
    logic    owner;
    logic    last_grant;
  } arb_dbg_t;

endpackage

// File: rtl/CacheReq.sv
// Cache request bundle. A transfer happens on a cycle where valid & ready are
// both high; the sender holds addr/wen/wdata stable until then.
interface CacheReq;
  import ptw_mem_arbiter_pkg::*;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic              ready;

  modport master (output valid, output addr, output wen, output wdata, input ready);
  modport slave  (input valid, input addr, input wen, input wdata, output ready);
endinterface

// File: rtl/CacheResp.sv
// Cache response bundle: a single-cycle valid pulse carrying read data and
// fault status; there is no back-pressure.
interface CacheResp;
  import ptw_mem_arbiter_pkg::*;

  logic              valid;
  logic [DATA_W-1:0] rdata;
  logic              error;
  FaultTy            errty;

  modport source (output valid, output rdata, output error, output errty);
  modport sink   (input valid, input rdata, input error, input errty);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: round-robin against the last winner, or
// fixed priority to port 0 when mode is set.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  input  logic mode,
  output logic grant0,
  output logic grant1
);

  // On a tie, round-robin favours the port that did not win last time.
  assign grant0 = valid0 & (~valid1 | mode | last);
  assign grant1 = valid1 & (~valid0 | (~mode & ~last));

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one cache port between the instruction-side (port 0) and data-side
// (port 1) page table walkers, one transaction in flight at a time.
module ptw_mem_arbiter
  import ptw_mem_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = ARB_RR,
  parameter int LOG_ENABLE    = 0
) (
  input  logic            clk,
  input  logic            reset,
  CacheReq.slave          req0,
  CacheResp.source        resp0,
  CacheReq.slave          req1,
  CacheResp.source        resp1,
  CacheReq.master         memreq,
  CacheResp.sink          memresp,
  output logic            busy,
  output logic [31:0]     grant_cnt0,
  output logic [31:0]     grant_cnt1,
  output arb_dbg_t        dbg
);

  arbstate      state;
  logic         owner;
  logic         last_grant;
  req_payload_t s_req;

  logic grant0, grant1;
  logic acc0, acc1;
  logic resp_fire;

  rr_arbiter2 u_arb (
    .valid0 (req0.valid),
    .valid1 (req1.valid),
    .last   (last_grant),
    .mode   (PRIORITY_MODE == ARB_FIXED),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0.ready = (state == IDLE) & grant0;
  assign req1.ready = (state == IDLE) & grant1;
  assign acc0       = req0.valid & req0.ready;
  assign acc1       = req1.valid & req1.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      s_req      <= '0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0) begin
            s_req      <= '{addr: req0.addr, wen: req0.wen, wdata: req0.wdata};
            owner      <= 1'b0;
            last_grant <= 1'b0;
            grant_cnt0 <= grant_cnt0 + 32'd1;
            state      <= ISSUE;
          end else if (acc1) begin
            s_req      <= '{addr: req1.addr, wen: req1.wen, wdata: req1.wdata};
            owner      <= 1'b1;
            last_grant <= 1'b1;
            grant_cnt1 <= grant_cnt1 + 32'd1;
            state      <= ISSUE;
          end
        end
        // Writes complete on the handshake; reads wait for one response.
        ISSUE: begin
          if (memreq.ready) state <= s_req.wen ? IDLE : WAIT_RESP;
        end
        WAIT_RESP: begin
          if (memresp.valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign memreq.valid = (state == ISSUE);
  assign memreq.addr  = s_req.addr;
  assign memreq.wen   = s_req.wen;
  assign memreq.wdata = s_req.wdata;

  // Responses outside WAIT_RESP (stale or spurious) are never routed.
  assign resp_fire = (state == WAIT_RESP) & memresp.valid;

  assign resp0.valid = resp_fire & ~owner;
  assign resp0.rdata = ~owner ? memresp.rdata : '0;
  assign resp0.error = ~owner ? memresp.error : 1'b0;
  assign resp0.errty = ~owner ? memresp.errty : FE_NONE;

  assign resp1.valid = resp_fire & owner;
  assign resp1.rdata = owner ? memresp.rdata : '0;
  assign resp1.error = owner ? memresp.error : 1'b0;
  assign resp1.errty = owner ? memresp.errty : FE_NONE;

  assign busy = (state != IDLE);

  always_comb begin
    dbg = '0;
    if (LOG_ENABLE != 0) begin
      dbg.state      = state;
      dbg.owner      = owner;
      dbg.last_grant = last_grant;
    end
  end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: one round-robin and one fixed-priority
// instance, driven and checked step by step from a single initial block.
module tb_ptw_mem_arbiter;
  import ptw_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  CacheReq  rr_req0 ();
  CacheReq  rr_req1 ();
  CacheResp rr_resp0 ();
  CacheResp rr_resp1 ();
  CacheReq  rr_mreq ();
  CacheResp rr_mresp ();
  logic        rr_busy;
  logic [31:0] rr_cnt0, rr_cnt1;
  arb_dbg_t    rr_dbg;

  CacheReq  fx_req0 ();
  CacheReq  fx_req1 ();
  CacheResp fx_resp0 ();
  CacheResp fx_resp1 ();
  CacheReq  fx_mreq ();
  CacheResp fx_mresp ();
  logic        fx_busy;
  logic [31:0] fx_cnt0, fx_cnt1;
  arb_dbg_t    fx_dbg;

  ptw_mem_arbiter #(.PRIORITY_MODE(ARB_RR), .LOG_ENABLE(1)) u_rr (
    .clk(clk), .reset(reset),
    .req0(rr_req0), .resp0(rr_resp0), .req1(rr_req1), .resp1(rr_resp1),
    .memreq(rr_mreq), .memresp(rr_mresp),
    .busy(rr_busy), .grant_cnt0(rr_cnt0), .grant_cnt1(rr_cnt1), .dbg(rr_dbg)
  );

  ptw_mem_arbiter #(.PRIORITY_MODE(ARB_FIXED), .LOG_ENABLE(1)) u_fx (
    .clk(clk), .reset(reset),
    .req0(fx_req0), .resp0(fx_resp0), .req1(fx_req1), .resp1(fx_resp1),
    .memreq(fx_mreq), .memresp(fx_mresp),
    .busy(fx_busy), .grant_cnt0(fx_cnt0), .grant_cnt1(fx_cnt1), .dbg(fx_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    rr_req0.valid = 0; rr_req0.addr = '0; rr_req0.wen = 0; rr_req0.wdata = '0;
    rr_req1.valid = 0; rr_req1.addr = '0; rr_req1.wen = 0; rr_req1.wdata = '0;
    rr_mreq.ready = 0;
    rr_mresp.valid = 0; rr_mresp.rdata = '0; rr_mresp.error = 0; rr_mresp.errty = FE_NONE;
    fx_req0.valid = 0; fx_req0.addr = '0; fx_req0.wen = 0; fx_req0.wdata = '0;
    fx_req1.valid = 0; fx_req1.addr = '0; fx_req1.wen = 0; fx_req1.wdata = '0;
    fx_mreq.ready = 0;
    fx_mresp.valid = 0; fx_mresp.rdata = '0; fx_mresp.error = 0; fx_mresp.errty = FE_NONE;
  endtask

  // One read on the round-robin instance with a 1-cycle memory; requests are
  // already presented by the caller while the arbiter sits in IDLE.
  task automatic rr_read(input int port, input logic [31:0] addr, input logic [31:0] data,
                         input logic err, input FaultTy ety);
    #1;
    chk("rr_ready0", 32'(rr_req0.ready), 32'(port == 0));
    chk("rr_ready1", 32'(rr_req1.ready), 32'(port == 1));
    tick();
    chk("rr_mreq_valid", 32'(rr_mreq.valid), 32'd1);
    chk("rr_mreq_addr", rr_mreq.addr, addr);
    chk("rr_mreq_wen", 32'(rr_mreq.wen), 32'd0);
    rr_mreq.ready = 1'b1;
    tick();
    rr_mreq.ready  = 1'b0;
    rr_mresp.valid = 1'b1;
    rr_mresp.rdata = data;
    rr_mresp.error = err;
    rr_mresp.errty = ety;
    #1;
    chk("rr_mreq_dropped", 32'(rr_mreq.valid), 32'd0);
    chk("rr_resp0_valid", 32'(rr_resp0.valid), 32'(port == 0));
    chk("rr_resp1_valid", 32'(rr_resp1.valid), 32'(port == 1));
    chk("rr_resp_rdata", (port == 0) ? rr_resp0.rdata : rr_resp1.rdata, data);
    chk("rr_resp_error", 32'((port == 0) ? rr_resp0.error : rr_resp1.error), 32'(err));
    chk("rr_resp_errty", 32'((port == 0) ? rr_resp0.errty : rr_resp1.errty), 32'(ety));
    tick();
    rr_mresp.valid = 1'b0;
    rr_mresp.rdata = '0;
    rr_mresp.error = 1'b0;
    rr_mresp.errty = FE_NONE;
  endtask

  task automatic fx_read(input int port, input logic [31:0] addr, input logic [31:0] data);
    #1;
    chk("fx_ready0", 32'(fx_req0.ready), 32'(port == 0));
    chk("fx_ready1", 32'(fx_req1.ready), 32'(port == 1));
    tick();
    chk("fx_mreq_addr", fx_mreq.addr, addr);
    fx_mreq.ready = 1'b1;
    tick();
    fx_mreq.ready  = 1'b0;
    fx_mresp.valid = 1'b1;
    fx_mresp.rdata = data;
    #1;
    chk("fx_resp0_valid", 32'(fx_resp0.valid), 32'(port == 0));
    chk("fx_resp1_valid", 32'(fx_resp1.valid), 32'(port == 1));
    chk("fx_resp_rdata", (port == 0) ? fx_resp0.rdata : fx_resp1.rdata, data);
    tick();
    fx_mresp.valid = 1'b0;
    fx_mresp.rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_inputs();
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("reset_busy", 32'(rr_busy), 32'd0);
    chk("reset_mreq_valid", 32'(rr_mreq.valid), 32'd0);
    chk("reset_resp0_valid", 32'(rr_resp0.valid), 32'd0);
    chk("reset_resp1_valid", 32'(rr_resp1.valid), 32'd0);
    chk("reset_cnt0", rr_cnt0, 32'd0);
    chk("reset_cnt1", rr_cnt1, 32'd0);
    chk("reset_state", 32'(rr_dbg.state), 32'(IDLE));
    chk("reset_last_grant", 32'(rr_dbg.last_grant), 32'd1);
    reset = 1'b0;

    // Single read on port 0
    rr_req0.valid = 1'b1;
    rr_req0.addr  = 32'h8000_1000;
    rr_read(0, 32'h8000_1000, 32'hDEAD_BEEF, 1'b0, FE_NONE);
    rr_req0.valid = 1'b0;
    #1;
    chk("t1_busy_done", 32'(rr_busy), 32'd0);
    chk("t1_cnt0", rr_cnt0, 32'd1);
    chk("t1_cnt1", rr_cnt1, 32'd0);

    // Stray response while IDLE is not routed
    rr_mresp.valid = 1'b1;
    rr_mresp.rdata = 32'h1111_2222;
    #1;
    chk("idle_resp0_quiet", 32'(rr_resp0.valid), 32'd0);
    chk("idle_resp1_quiet", 32'(rr_resp1.valid), 32'd0);
    tick();
    rr_mresp.valid = 1'b0;
    chk("idle_resp_state", 32'(rr_dbg.state), 32'(IDLE));

    // Error read on port 1, fault forwarded verbatim
    rr_req1.valid = 1'b1;
    rr_req1.addr  = 32'h0000_0300;
    rr_read(1, 32'h0000_0300, 32'h1234_5678, 1'b1, FE_ACCESS_FAULT);
    rr_req1.valid = 1'b0;
    chk("t5_cnt1", rr_cnt1, 32'd1);

    // Write on port 1 with memreq.ready held off for 3 cycles
    rr_req1.valid = 1'b1;
    rr_req1.wen   = 1'b1;
    rr_req1.addr  = 32'h8000_2004;
    rr_req1.wdata = 32'h0000_00CF;
    #1;
    chk("t4_ready1", 32'(rr_req1.ready), 32'd1);
    tick();
    rr_req1.valid  = 1'b0;
    rr_req1.wen    = 1'b0;
    rr_req1.wdata  = '0;
    rr_req0.valid  = 1'b1;
    rr_req0.addr   = 32'h0000_0999;
    rr_mresp.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_mreq_valid", 32'(rr_mreq.valid), 32'd1);
      chk("t4_mreq_addr", rr_mreq.addr, 32'h8000_2004);
      chk("t4_mreq_wen", 32'(rr_mreq.wen), 32'd1);
      chk("t4_mreq_wdata", rr_mreq.wdata, 32'h0000_00CF);
      chk("t4_ready0_busy", 32'(rr_req0.ready), 32'd0);
      chk("t4_issue_resp_quiet", 32'(rr_resp0.valid | rr_resp1.valid), 32'd0);
      tick();
      rr_req0.valid  = 1'b0;
      rr_mresp.valid = 1'b0;
    end
    rr_mreq.ready = 1'b1;
    #1;
    chk("t4_mreq_hold", 32'(rr_mreq.valid), 32'd1);
    tick();
    rr_mreq.ready = 1'b0;
    #1;
    chk("t4_busy_done", 32'(rr_busy), 32'd0);
    chk("t4_mreq_released", 32'(rr_mreq.valid), 32'd0);
    chk("t4_no_resp", 32'(rr_resp0.valid | rr_resp1.valid), 32'd0);
    chk("t4_cnt0_unchanged", rr_cnt0, 32'd1);
    chk("t4_cnt1", rr_cnt1, 32'd2);
    tick();
    chk("t4_dropped_req_ignored", 32'(rr_busy), 32'd0);

    // Round-robin tie: 4 reads alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t2_cnt0_cleared", rr_cnt0, 32'd0);
    chk("t2_cnt1_cleared", rr_cnt1, 32'd0);
    rr_req0.valid = 1'b1;
    rr_req0.addr  = 32'h0000_0100;
    rr_req1.valid = 1'b1;
    rr_req1.addr  = 32'h0000_0200;
    rr_read(0, 32'h0000_0100, 32'h0000_A000, 1'b0, FE_NONE);
    rr_read(1, 32'h0000_0200, 32'h0000_A001, 1'b0, FE_NONE);
    rr_read(0, 32'h0000_0100, 32'h0000_A002, 1'b0, FE_NONE);
    rr_read(1, 32'h0000_0200, 32'h0000_A003, 1'b0, FE_NONE);
    rr_req0.valid = 1'b0;
    rr_req1.valid = 1'b0;
    chk("t2_cnt0", rr_cnt0, 32'd2);
    chk("t2_cnt1", rr_cnt1, 32'd2);

    // Reset while waiting for a read response; the late response is dropped
    rr_req0.valid = 1'b1;
    rr_req0.addr  = 32'h0000_0400;
    tick();
    rr_req0.valid = 1'b0;
    rr_mreq.ready = 1'b1;
    tick();
    rr_mreq.ready = 1'b0;
    #1;
    chk("t6_wait_state", 32'(rr_dbg.state), 32'(WAIT_RESP));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr_mresp.valid = 1'b1;
    rr_mresp.rdata = 32'h0000_0055;
    #1;
    chk("t6_resp0_quiet", 32'(rr_resp0.valid), 32'd0);
    chk("t6_resp1_quiet", 32'(rr_resp1.valid), 32'd0);
    chk("t6_busy", 32'(rr_busy), 32'd0);
    chk("t6_cnt0", rr_cnt0, 32'd0);
    chk("t6_cnt1", rr_cnt1, 32'd0);
    tick();
    rr_mresp.valid = 1'b0;
    rr_req0.valid  = 1'b1;
    rr_req1.valid  = 1'b1;
    #1;
    chk("t6_tie_ready0", 32'(rr_req0.ready), 32'd1);
    chk("t6_tie_ready1", 32'(rr_req1.ready), 32'd0);
    rr_req0.valid = 1'b0;
    rr_req1.valid = 1'b0;
    tick();

    // Fixed priority: port 0 wins every tie until it drops valid
    fx_req0.valid = 1'b1;
    fx_req0.addr  = 32'h0000_0100;
    fx_req1.valid = 1'b1;
    fx_req1.addr  = 32'h0000_0200;
    fx_read(0, 32'h0000_0100, 32'h0000_B000);
    fx_read(0, 32'h0000_0100, 32'h0000_B001);
    fx_read(0, 32'h0000_0100, 32'h0000_B002);
    fx_req0.valid = 1'b0;
    fx_read(1, 32'h0000_0200, 32'h0000_B100);
    fx_req1.valid = 1'b0;
    chk("t3_cnt0", fx_cnt0, 32'd3);
    chk("t3_cnt1", fx_cnt1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ptw_mem_arbiter.md
Name: ptw_mem_arbiter

Overview:
Shares one memory port (CacheReq/CacheResp) between the instruction-side page table walker (port 0) and the data-side page table walker (port 1).
- At most one transaction is in flight.
- Grants are round-robin or fixed-priority; the choice is made at elaboration.
- Each read response is routed back to the requester that issued it.
- Sits between the two walkers and the shared cache/memory controller.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed priority, port 0 wins ties.
- LOG_ENABLE, 0: enables PRINT_DEBUGINFO data lines.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req0  inout  CacheReq  port 0 request. valid/addr/wen/wdata are inputs; ready is driven by this block.
- resp0  inout  CacheResp  port 0 response. valid/rdata/error/errty are driven by this block.
- req1  inout  CacheReq  port 1 request, same field directions as req0.
- resp1  inout  CacheResp  port 1 response, same field directions as resp0.
- memreq  inout  CacheReq  shared memory request. valid/addr/wen/wdata are driven by this block; ready is an input.
- memresp  inout  CacheResp  shared memory response; all fields are inputs.
- busy  out  1  high whenever state != IDLE
- grant_cnt0  out  32  number of requests accepted on port 0; wraps at 2^32
- grant_cnt1  out  32  number of requests accepted on port 1; wraps at 2^32

Behaviour:
- Memory contract: a read returns exactly one memresp.valid pulse. A write completes when memreq.valid & memreq.ready, with no response.
- States: IDLE, ISSUE, WAIT_RESP.
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), owner=0.
  - grant_cnt0/1=0; stored request cleared.
  - Outputs at reset: memreq.valid=0, resp0.valid=0, resp1.valid=0.
- Grant selection (combinational, IDLE only):
  - Only one port valid → that port.
  - Both valid, PRIORITY_MODE=0 → the port != last_grant.
  - Both valid, PRIORITY_MODE=1 → port 0.
- Ready outputs: reqN.ready = (state==IDLE) & grantN. Both readys are 0 outside IDLE.
- IDLE, on an accepted request:
  - latch the request into s_req and set owner=N, last_grant=N.
  - grant_cntN += 1.
  - go to ISSUE.
- ISSUE:
  - memreq.valid=1; memreq.addr/wen/wdata driven from s_req.
  - On memreq.ready: a write goes to IDLE; a read goes to WAIT_RESP.
  - s_req stays stable while memreq.valid=1.
- WAIT_RESP:
  - memreq.valid=0.
  - On memresp.valid: resp[owner].valid=1 for that same cycle (combinational pass-through). rdata/error/errty are copied from memresp. Go to IDLE.
  - resp[!owner].valid stays 0 throughout.
- Non-owner response fields: rdata/error/errty for the non-owner are don't-care while its valid=0 (drive 0).
- Latency:
  - Read: accept cycle → ISSUE next cycle → response the same cycle as memresp.valid. Minimum 3 cycles accept-to-resp with a 1-cycle memory.
  - Write: minimum 2 cycles accept-to-done.
- Throughput and fairness:
  - IDLE is re-entered for at least one cycle between transactions, so at most one accept per 2 cycles.
  - Round-robin guarantees alternation when both ports are continuously valid.
- Boundary conditions:
  - memresp.valid in IDLE or ISSUE: ignored, not routed.
  - memresp.error=1 in WAIT_RESP: forwarded verbatim; no retry.
  - A requester may drop valid before ready; nothing is latched.
  - Reset mid-transaction: return to IDLE immediately; a late memresp is then dropped under the IDLE rule.
  - Counters wrap from 32'hFFFFFFFF to 0.

Decomposition:
- CacheReq, CacheResp, FaultTy: from the existing shared package (no change).
- New in the same package:
  - arbstate enum {IDLE, ISSUE, WAIT_RESP} (2 bits).
  - ARB_RR=0 and ARB_FIXED=1 constants for PRIORITY_MODE.
- Sub-module rr_arbiter2: inputs valid0, valid1, last, mode; outputs grant0, grant1. Purely combinational and reusable.

Test Plan:
1. Single read: port 0 read at addr 0x8000_1000. Memory returns rdata 0xDEADBEEF after 1 cycle → resp0.valid pulses once with 0xDEADBEEF, resp1 silent, grant_cnt0=1.
2. Tie, round-robin: both ports hold valid reads (0x100, 0x200) for 4 transactions → grant order 0,1,0,1; each response reaches the correct port; grant_cnt0=grant_cnt1=2.
3. Tie, PRIORITY_MODE=1: both valid continuously → port 0 is granted every time and port 1 waits. Drop port 0 valid → port 1 is granted on the next IDLE.
4. Write: port 1 writes wdata 0x000000CF to 0x8000_2004 with memreq.ready delayed 3 cycles → memreq fields stable throughout; return to IDLE with no resp; busy deasserts.
5. Error: port 1 read where memresp returns error=1, errty=FE_ACCESS_FAULT → resp1.error=1 with errty preserved.
6. Reset in WAIT_RESP, then memresp.valid the cycle after reset → no resp pulse on either port; counters=0; the next tie grants port 0.
